// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: parametrised decode->execute pipeline stage register.
//
// Carries r1/r2/rd, imm, pc, op_data, func3 (in_instr[14:12]) and alu_cmd
// downstream under a valid/ready handshake. The stage also supports:
//   - a synchronous global enable (en)
//   - flush, which inserts a bubble
//   - a saturating counter of backpressured cycles
//
// Build option: PIPE_SKID_EN
//   defined   : 2-entry skid buffer. in_ready comes from a register only,
//               so there is no combinational out_ready->in_ready path.
//   undefined : single register. in_ready = en && (!out_valid || out_ready).
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous active-low reset
//   en                   synchronous enable; 0 freezes every register, in_ready=0
//   flush                empties the stage and drops this cycle's input
//   in_valid/in_ready    upstream handshake
//   in_r1/in_r2/in_rd, in_imm, in_pc, in_instr, in_op_data, in_alu_cmd
//                        payload from decode
//   out_valid/out_ready  downstream handshake
//   out_r1/out_r2/out_rd, out_imm, out_pc, out_op_data, out_func3, out_alu_cmd
//                        registered payload
//   stall_cnt            en cycles with out_valid && !out_ready; saturates
//
// Skid FSM (PIPE_SKID_EN only)
//   state    | meaning
//   ST_EMPTY | no entry held, out_valid=0
//   ST_MAIN  | one entry, in the output register
//   ST_SKID  | two entries: output register + skid register, in_ready=0
module pipe_stage_hs #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int OPD_W = 15,
  parameter int ALU_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_r1,
  input  logic [REG_W-1:0] in_r2,
  input  logic [REG_W-1:0] in_rd,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  input  logic [OPD_W-1:0] in_op_data,
  input  logic [ALU_W-1:0] in_alu_cmd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_r1,
  output logic [REG_W-1:0] out_r2,
  output logic [REG_W-1:0] out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [OPD_W-1:0] out_op_data,
  output logic [2:0]       out_func3,
  output logic [ALU_W-1:0] out_alu_cmd,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PW = 3*REG_W + 2*XLEN + OPD_W + 3 + ALU_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]    in_pay;
  logic [PW-1:0]    main_q;
  logic [CNT_W-1:0] cnt_q;
  logic             xfer_in;
  logic             xfer_out;
  logic             unused_instr;

  assign in_pay = {in_r1, in_r2, in_rd, in_imm, in_pc, in_instr[14:12],
                   in_op_data, in_alu_cmd};
  assign {out_r1, out_r2, out_rd, out_imm, out_pc, out_func3,
          out_op_data, out_alu_cmd} = main_q;

  // Only func3 is taken from the raw instruction.
  assign unused_instr = ^{in_instr[31:15], in_instr[11:0]};

  assign xfer_in  = in_valid && in_ready && en && !flush;
  assign xfer_out = out_valid && out_ready && en;

  // Backpressure counter. It is deliberately left untouched by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (en && out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cnt = cnt_q;

`ifdef PIPE_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] skid_q;
  logic          main_ld;
  logic          main_from_skid;
  logic          skid_ld;

  // in_ready depends only on the state register and en, never on out_ready.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = en && (state_q != ST_SKID);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (en) begin
      if (flush) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (xfer_in) begin
              state_d = ST_MAIN;
              main_ld = 1'b1;
            end
          end
          ST_MAIN: begin
            if (xfer_in && xfer_out) begin
              // Full throughput: the new entry replaces the departing one.
              main_ld = 1'b1;
            end else if (xfer_in) begin
              state_d = ST_SKID;
              skid_ld = 1'b1;
            end else if (xfer_out) begin
              state_d = ST_EMPTY;
            end
          end
          ST_SKID: begin
            // in_ready is 0 here, so only the unload needs handling.
            if (xfer_out) begin
              state_d        = ST_MAIN;
              main_ld        = 1'b1;
              main_from_skid = 1'b1;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_ld) begin
        main_q <= main_from_skid ? skid_q : in_pay;
      end
      if (skid_ld) begin
        skid_q <= in_pay;
      end
    end
  end

`else

  logic valid_q;

  assign out_valid = valid_q;
  assign in_ready  = en && (!valid_q || out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else if (en) begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (xfer_in) begin
        valid_q <= 1'b1;
      end else if (xfer_out) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Payload loads only on an accepted entry; bubbles leave it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
    end else if (xfer_in) begin
      main_q <= in_pay;
    end
  end

`endif

endmodule
